// File: rtl/change_dispenser_if.sv
// Handshake/status bundle between the vending calculator and the change dispenser.
// The dispenser sits on the slave side; the calculator and top level sit on the master side.
interface change_dispenser_if #(
    parameter int kNumCoins  = 3,
    parameter int kTotalBits = 31
);
    logic                  i_trigger_return;
    logic                  i_activity;
    logic [kTotalBits-1:0] i_current_total;
    logic [kNumCoins-1:0]  o_return_coin;
    logic                  o_return_busy;
    logic                  o_return_done;
    logic [31:0]           o_wait_time;

    modport slave (
        input  i_trigger_return, i_activity, i_current_total,
        output o_return_coin, o_return_busy, o_return_done, o_wait_time
    );

    modport master (
        output i_trigger_return, i_activity, i_current_total,
        input  o_return_coin, o_return_busy, o_return_done, o_wait_time
    );
endinterface

// File: rtl/change_dispenser.sv
// Sequences coin returns (largest denomination first, one per cycle) and runs the inactivity timer.
// First coin is visible one edge after the request is sampled; done pulses for one cycle at the end.
module change_dispenser #(
    parameter int kNumCoins  = 3,
    parameter int kTotalBits = 31,
    parameter int kWaitTime  = 10,
    parameter int COIN0      = 100,
    parameter int COIN1      = 500,
    parameter int COIN2      = 1000
) (
    input  logic                clk,
    input  logic                reset,
    change_dispenser_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RETURN = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [kTotalBits-1:0] kCoin0 = kTotalBits'(COIN0);
    localparam logic [kTotalBits-1:0] kCoin1 = kTotalBits'(COIN1);
    localparam logic [kTotalBits-1:0] kCoin2 = kTotalBits'(COIN2);
    localparam logic [kNumCoins-1:0]  kOh0   = kNumCoins'(1);
    localparam logic [kNumCoins-1:0]  kOh1   = kNumCoins'(2);
    localparam logic [kNumCoins-1:0]  kOh2   = kNumCoins'(4);
    localparam logic [31:0]           kWait  = 32'(kWaitTime);

    state_t                state_q, state_d;
    logic [kTotalBits-1:0] remaining_q, remaining_d;
    logic [kNumCoins-1:0]  coin_q, coin_d;
    logic                  done_q, done_d;
    logic [31:0]           wait_q, wait_d;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        coin_d      = '0;
        wait_d      = wait_q;
        unique case (state_q)
            IDLE: begin
                if (bus.i_trigger_return) begin
                    state_d     = RETURN;
                    remaining_d = bus.i_current_total;
                end else if (bus.i_activity) begin
                    wait_d = kWait;
                end else if (wait_q == 32'd0 && bus.i_current_total != '0) begin
                    state_d     = RETURN;
                    remaining_d = bus.i_current_total;
                end else if (wait_q != 32'd0) begin
                    wait_d = wait_q - 32'd1;
                end
            end
            RETURN: begin
                // Residue below the smallest coin is abandoned on the way to DONE.
                if (remaining_q >= kCoin2) begin
                    coin_d      = kOh2;
                    remaining_d = remaining_q - kCoin2;
                end else if (remaining_q >= kCoin1) begin
                    coin_d      = kOh1;
                    remaining_d = remaining_q - kCoin1;
                end else if (remaining_q >= kCoin0) begin
                    coin_d      = kOh0;
                    remaining_d = remaining_q - kCoin0;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                wait_d  = kWait;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            coin_q      <= '0;
            done_q      <= 1'b0;
            wait_q      <= kWait;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            coin_q      <= coin_d;
            done_q      <= done_d;
            wait_q      <= wait_d;
        end
    end

    assign bus.o_return_coin = coin_q;
    assign bus.o_return_done = done_q;
    assign bus.o_wait_time   = wait_q;
    assign bus.o_return_busy = (state_q != IDLE);
endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: expected coins are queued when a return is provoked
// and popped as the dispenser emits them.
module tb_change_dispenser;
    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;
    logic [2:0] exp_q[$];

    change_dispenser_if #(.kNumCoins(3), .kTotalBits(31)) bus ();

    change_dispenser dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called one cycle after the dispenser entered RETURN; consumes the queued coins.
    task automatic drain(input string tag);
        logic [2:0] e;
        while (exp_q.size() != 0) begin
            tick();
            e = exp_q.pop_front();
            check({tag, "_coin"}, 32'(bus.o_return_coin), 32'(e));
            check({tag, "_nodone"}, 32'(bus.o_return_done), 32'd0);
        end
        tick();
        check({tag, "_endcoin"}, 32'(bus.o_return_coin), 32'd0);
        check({tag, "_done"}, 32'(bus.o_return_done), 32'd1);
        check({tag, "_busydone"}, 32'(bus.o_return_busy), 32'd1);
        tick();
        check({tag, "_donefall"}, 32'(bus.o_return_done), 32'd0);
        check({tag, "_idle"}, 32'(bus.o_return_busy), 32'd0);
        check({tag, "_reload"}, bus.o_wait_time, 32'd10);
    endtask

    initial begin
        int n;
        bus.i_trigger_return = 1'b0;
        bus.i_activity       = 1'b0;
        bus.i_current_total  = '0;
        reset = 1'b1;
        tick();
        tick();
        check("rst_wait", bus.o_wait_time, 32'd10);
        check("rst_coin", 32'(bus.o_return_coin), 32'd0);
        check("rst_busy", 32'(bus.o_return_busy), 32'd0);
        check("rst_done", 32'(bus.o_return_done), 32'd0);
        reset = 1'b0;

        // 1600 on request: 1000, 500, 100
        bus.i_current_total  = 31'd1600;
        bus.i_trigger_return = 1'b1;
        tick();
        bus.i_trigger_return = 1'b0;
        check("t1600_busy", 32'(bus.o_return_busy), 32'd1);
        check("t1600_nocoin", 32'(bus.o_return_coin), 32'd0);
        exp_q.push_back(3'b100);
        exp_q.push_back(3'b010);
        exp_q.push_back(3'b001);
        drain("t1600");

        // Zero balance: timer runs down and holds at 0 with no return
        bus.i_current_total = '0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            check("cnt_down", bus.o_wait_time, 32'(10 - i));
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            check("cnt_hold", bus.o_wait_time, 32'd0);
            check("cnt_idle", 32'(bus.o_return_busy), 32'd0);
        end
        bus.i_current_total = 31'd500;
        tick();
        check("to500_busy", 32'(bus.o_return_busy), 32'd1);
        exp_q.push_back(3'b010);
        drain("to500");

        // 300 with an activity pulse at wait=3, then timeout
        bus.i_current_total = 31'd300;
        for (int i = 0; i < 7; i++) tick();
        check("act_pre", bus.o_wait_time, 32'd3);
        bus.i_activity = 1'b1;
        tick();
        bus.i_activity = 1'b0;
        check("act_reload", bus.o_wait_time, 32'd10);
        check("act_idle", 32'(bus.o_return_busy), 32'd0);
        exp_q.push_back(3'b001);
        exp_q.push_back(3'b001);
        exp_q.push_back(3'b001);
        n = 0;
        while (bus.o_return_busy !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
        check("to300_edges", 32'(n), 32'd11);
        drain("to300");

        // 2050: residue 50 dropped
        bus.i_current_total  = 31'd2050;
        bus.i_trigger_return = 1'b1;
        tick();
        bus.i_trigger_return = 1'b0;
        exp_q.push_back(3'b100);
        exp_q.push_back(3'b100);
        drain("t2050");

        // Zero-balance request: one RETURN cycle, no coins, then done
        bus.i_current_total  = '0;
        bus.i_trigger_return = 1'b1;
        tick();
        bus.i_trigger_return = 1'b0;
        check("t0_busy", 32'(bus.o_return_busy), 32'd1);
        drain("t0");

        // Inputs ignored during RETURN, then reset mid-sequence
        bus.i_current_total  = 31'd1600;
        bus.i_trigger_return = 1'b1;
        tick();
        tick();
        check("mid_coin1", 32'(bus.o_return_coin), 32'b100);
        bus.i_activity      = 1'b1;
        bus.i_current_total = 31'd0;
        tick();
        check("mid_coin2", 32'(bus.o_return_coin), 32'b010);
        check("mid_wait", bus.o_wait_time, 32'd10);
        bus.i_trigger_return = 1'b0;
        bus.i_activity       = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mrst_coin", 32'(bus.o_return_coin), 32'd0);
        check("mrst_busy", 32'(bus.o_return_busy), 32'd0);
        check("mrst_done", 32'(bus.o_return_done), 32'd0);
        check("mrst_wait", bus.o_wait_time, 32'd10);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_coin", 32'(bus.o_return_coin), 32'd0);
            check("post_done", 32'(bus.o_return_done), 32'd0);
            check("post_busy", 32'(bus.o_return_busy), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
